// File: rtl/axi_rd_arb_pkg.sv
// Shared types and helpers for the two-port AXI read arbiter.
package axi_rd_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef logic [0:0] port_idx_t;

  function automatic port_idx_t rr_next(input port_idx_t idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/axi_rd_arb_txn_cnt.sv
// Saturating outstanding-burst counter; one instance per requester port.
module axi_rd_arb_txn_cnt #(
  parameter int MAX_TXNS = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int CW = $clog2(MAX_TXNS + 1);

  logic [CW-1:0] cnt_q;

  // Simultaneous issue and completion cancel; both ends saturate.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && (cnt_q != CW'(MAX_TXNS))) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign full_o  = (cnt_q == CW'(MAX_TXNS));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/axi_rd_arbiter_2to1.sv
// Two requesters share one AXI4 read master: round-robin AR through a one-deep
// register, requester index carried in the ARID MSB and used to route R back.
module axi_rd_arbiter_2to1
  import axi_rd_arb_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_TXNS   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ID_WIDTH-1:0]   s0_ar_arid,
  input  logic [ADDR_WIDTH-1:0] s0_ar_araddr,
  input  logic [7:0]            s0_ar_arlen,
  input  logic [2:0]            s0_ar_arsize,
  input  logic [1:0]            s0_ar_arburst,
  input  logic                  s0_ar_arvalid,
  output logic                  s0_ar_arready,
  output logic [ID_WIDTH-1:0]   s0_r_rid,
  output logic [DATA_WIDTH-1:0] s0_r_rdata,
  output logic [1:0]            s0_r_rresp,
  output logic                  s0_r_rlast,
  output logic                  s0_r_rvalid,
  input  logic                  s0_r_rready,
  input  logic [ID_WIDTH-1:0]   s1_ar_arid,
  input  logic [ADDR_WIDTH-1:0] s1_ar_araddr,
  input  logic [7:0]            s1_ar_arlen,
  input  logic [2:0]            s1_ar_arsize,
  input  logic [1:0]            s1_ar_arburst,
  input  logic                  s1_ar_arvalid,
  output logic                  s1_ar_arready,
  output logic [ID_WIDTH-1:0]   s1_r_rid,
  output logic [DATA_WIDTH-1:0] s1_r_rdata,
  output logic [1:0]            s1_r_rresp,
  output logic                  s1_r_rlast,
  output logic                  s1_r_rvalid,
  input  logic                  s1_r_rready,
  output logic [ID_WIDTH:0]     m_ar_arid,
  output logic [ADDR_WIDTH-1:0] m_ar_araddr,
  output logic [7:0]            m_ar_arlen,
  output logic [2:0]            m_ar_arsize,
  output logic [1:0]            m_ar_arburst,
  output logic                  m_ar_arvalid,
  input  logic                  m_ar_arready,
  input  logic [ID_WIDTH:0]     m_r_rid,
  input  logic [DATA_WIDTH-1:0] m_r_rdata,
  input  logic [1:0]            m_r_rresp,
  input  logic                  m_r_rlast,
  input  logic                  m_r_rvalid,
  output logic                  m_r_rready,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef struct packed {
    logic [ID_WIDTH:0]     id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_chan_t;

  ar_chan_t  ar_q, ar_s0, ar_s1;
  logic      ar_valid_q;
  port_idx_t rr_ptr_q;
  logic      err_q;

  logic load, elig0, elig1, gnt0, gnt1;
  logic full0, full1, empty0, empty1;
  logic sel, r_hs, dec0, dec1;

  assign ar_s0 = '{id: {1'b0, s0_ar_arid}, addr: s0_ar_araddr, len: s0_ar_arlen,
                   size: s0_ar_arsize, burst: s0_ar_arburst};
  assign ar_s1 = '{id: {1'b1, s1_ar_arid}, addr: s1_ar_araddr, len: s1_ar_arlen,
                   size: s1_ar_arsize, burst: s1_ar_arburst};

  // The pointer port wins a tie; otherwise whichever port is eligible.
  assign load  = !ar_valid_q || m_ar_arready;
  assign elig0 = s0_ar_arvalid && !full0;
  assign elig1 = s1_ar_arvalid && !full1;
  assign gnt0  = load && elig0 && ((rr_ptr_q == 1'b0) || !elig1);
  assign gnt1  = load && elig1 && ((rr_ptr_q == 1'b1) || !elig0);

  assign s0_ar_arready = gnt0 && !rst_i;
  assign s1_ar_arready = gnt1 && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ar_valid_q <= 1'b0;
      ar_q       <= '0;
      rr_ptr_q   <= '0;
    end else if (gnt0 || gnt1) begin
      ar_valid_q <= 1'b1;
      ar_q       <= gnt1 ? ar_s1 : ar_s0;
      rr_ptr_q   <= rr_next(port_idx_t'(gnt1));
    end else if (m_ar_arready) begin
      ar_valid_q <= 1'b0;
    end
  end

  assign m_ar_arvalid = ar_valid_q;
  assign m_ar_arid    = ar_q.id;
  assign m_ar_araddr  = ar_q.addr;
  assign m_ar_arlen   = ar_q.len;
  assign m_ar_arsize  = ar_q.size;
  assign m_ar_arburst = ar_q.burst;

  // R path is pure steering on the ID MSB; payload goes to both ports.
  assign sel        = m_r_rid[ID_WIDTH];
  assign m_r_rready = sel ? s1_r_rready : s0_r_rready;
  assign r_hs       = m_r_rvalid && m_r_rready;
  assign dec0       = r_hs && m_r_rlast && !sel;
  assign dec1       = r_hs && m_r_rlast && sel;

  assign s0_r_rvalid = m_r_rvalid && !sel;
  assign s1_r_rvalid = m_r_rvalid && sel;
  assign s0_r_rid    = m_r_rid[ID_WIDTH-1:0];
  assign s1_r_rid    = m_r_rid[ID_WIDTH-1:0];
  assign s0_r_rdata  = m_r_rdata;
  assign s1_r_rdata  = m_r_rdata;
  assign s0_r_rresp  = m_r_rresp;
  assign s1_r_rresp  = m_r_rresp;
  assign s0_r_rlast  = m_r_rlast;
  assign s1_r_rlast  = m_r_rlast;

  axi_rd_arb_txn_cnt #(.MAX_TXNS(MAX_TXNS)) u_cnt0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (gnt0),
    .dec_i   (dec0),
    .full_o  (full0),
    .empty_o (empty0)
  );

  axi_rd_arb_txn_cnt #(.MAX_TXNS(MAX_TXNS)) u_cnt1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (gnt1),
    .dec_i   (dec1),
    .full_o  (full1),
    .empty_o (empty1)
  );

  // A beat for a port with nothing outstanding is a slave protocol error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (r_hs && (sel ? empty1 : empty0)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o  = err_q;
  assign busy_o = ar_valid_q || !empty0 || !empty1;

endmodule

// File: tb/tb_axi_rd_arbiter_2to1.sv
// Directed bench for axi_rd_arbiter_2to1 with an AR scoreboard and a
// cycle model of grants, outstanding counts, busy and the error flag.
module tb_axi_rd_arbiter_2to1;

  localparam int IDW  = 4;
  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int MAXT = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [IDW-1:0]  s0_ar_arid, s1_ar_arid;
  logic [AW-1:0]   s0_ar_araddr, s1_ar_araddr;
  logic [7:0]      s0_ar_arlen, s1_ar_arlen;
  logic [2:0]      s0_ar_arsize, s1_ar_arsize;
  logic [1:0]      s0_ar_arburst, s1_ar_arburst;
  logic            s0_ar_arvalid, s1_ar_arvalid;
  logic            s0_ar_arready, s1_ar_arready;
  logic [IDW-1:0]  s0_r_rid, s1_r_rid;
  logic [DW-1:0]   s0_r_rdata, s1_r_rdata;
  logic [1:0]      s0_r_rresp, s1_r_rresp;
  logic            s0_r_rlast, s1_r_rlast;
  logic            s0_r_rvalid, s1_r_rvalid;
  logic            s0_r_rready, s1_r_rready;
  logic [IDW:0]    m_ar_arid;
  logic [AW-1:0]   m_ar_araddr;
  logic [7:0]      m_ar_arlen;
  logic [2:0]      m_ar_arsize;
  logic [1:0]      m_ar_arburst;
  logic            m_ar_arvalid, m_ar_arready;
  logic [IDW:0]    m_r_rid;
  logic [DW-1:0]   m_r_rdata;
  logic [1:0]      m_r_rresp;
  logic            m_r_rlast, m_r_rvalid, m_r_rready;
  logic            busy_o, err_o;

  always #5 clk_i = ~clk_i;

  axi_rd_arbiter_2to1 #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_TXNS(MAXT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s0_ar_arid(s0_ar_arid), .s0_ar_araddr(s0_ar_araddr), .s0_ar_arlen(s0_ar_arlen),
    .s0_ar_arsize(s0_ar_arsize), .s0_ar_arburst(s0_ar_arburst),
    .s0_ar_arvalid(s0_ar_arvalid), .s0_ar_arready(s0_ar_arready),
    .s0_r_rid(s0_r_rid), .s0_r_rdata(s0_r_rdata), .s0_r_rresp(s0_r_rresp),
    .s0_r_rlast(s0_r_rlast), .s0_r_rvalid(s0_r_rvalid), .s0_r_rready(s0_r_rready),
    .s1_ar_arid(s1_ar_arid), .s1_ar_araddr(s1_ar_araddr), .s1_ar_arlen(s1_ar_arlen),
    .s1_ar_arsize(s1_ar_arsize), .s1_ar_arburst(s1_ar_arburst),
    .s1_ar_arvalid(s1_ar_arvalid), .s1_ar_arready(s1_ar_arready),
    .s1_r_rid(s1_r_rid), .s1_r_rdata(s1_r_rdata), .s1_r_rresp(s1_r_rresp),
    .s1_r_rlast(s1_r_rlast), .s1_r_rvalid(s1_r_rvalid), .s1_r_rready(s1_r_rready),
    .m_ar_arid(m_ar_arid), .m_ar_araddr(m_ar_araddr), .m_ar_arlen(m_ar_arlen),
    .m_ar_arsize(m_ar_arsize), .m_ar_arburst(m_ar_arburst),
    .m_ar_arvalid(m_ar_arvalid), .m_ar_arready(m_ar_arready),
    .m_r_rid(m_r_rid), .m_r_rdata(m_r_rdata), .m_r_rresp(m_r_rresp),
    .m_r_rlast(m_r_rlast), .m_r_rvalid(m_r_rvalid), .m_r_rready(m_r_rready),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    logic [IDW:0]  id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } ar_exp_t;

  ar_exp_t      exp_q[$];
  logic [IDW:0] resp_q[$];

  int   n_checks = 0;
  int   n_errs   = 0;
  logic m_vld;
  bit   ptr;
  int   cnt[2];
  logic err_m;
  int   seq[2];
  bit   auto_resp;
  int   grants_total;
  int   dut_hs;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errs++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    m_vld = 1'b0;
    ptr   = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
    err_m = 1'b0;
    exp_q.delete();
    resp_q.delete();
  endtask

  task automatic drivePayload();
    s0_ar_arid    = seq[0][IDW-1:0];
    s0_ar_araddr  = 64'hA000_0000_0000_0000 | 64'(seq[0]);
    s0_ar_arlen   = 8'(seq[0]);
    s0_ar_arsize  = 3'd3;
    s0_ar_arburst = 2'b01;
    s1_ar_arid    = seq[1][IDW-1:0] ^ 4'hA;
    s1_ar_araddr  = 64'hB000_0000_0000_0000 | 64'(seq[1]);
    s1_ar_arlen   = 8'(seq[1] + 128);
    s1_ar_arsize  = 3'd2;
    s1_ar_arburst = 2'b01;
  endtask

  // One clock of stimulus: drive, check at the falling edge, advance the model.
  task automatic applyStimulus(input logic v0, input logic v1, input logic mrdy,
                               input logic rv, input logic [IDW:0] rid, input logic rl,
                               input logic rr0, input logic rr1);
    logic    load, e0, e1, gp_valid, g0, g1, sel, rhs, inc, dec;
    bit      gp;
    ar_exp_t e;
    drivePayload();
    s0_ar_arvalid = v0;
    s1_ar_arvalid = v1;
    m_ar_arready  = mrdy;
    m_r_rvalid    = rv;
    m_r_rid       = rid;
    m_r_rlast     = rl;
    m_r_rresp     = rid[1:0];
    m_r_rdata     = 64'hDEAD_BEEF_0000_0000 | 64'(grants_total);
    s0_r_rready   = rr0;
    s1_r_rready   = rr1;
    @(negedge clk_i);
    load = !m_vld || mrdy;
    e0 = v0 && (cnt[0] < MAXT);
    e1 = v1 && (cnt[1] < MAXT);
    gp_valid = load && (e0 || e1);
    if (ptr == 1'b0) gp = e0 ? 1'b0 : 1'b1;
    else             gp = e1 ? 1'b1 : 1'b0;
    g0 = gp_valid && (gp == 1'b0);
    g1 = gp_valid && (gp == 1'b1);
    checkOutput("s0_arready", s0_ar_arready, g0);
    checkOutput("s1_arready", s1_ar_arready, g1);
    checkOutput("m_arvalid", m_ar_arvalid, m_vld);
    if (m_vld && exp_q.size() > 0) begin
      checkOutput("m_arid", m_ar_arid, exp_q[0].id);
      checkOutput("m_araddr", m_ar_araddr, exp_q[0].addr);
      checkOutput("m_arlen", m_ar_arlen, exp_q[0].len);
    end
    sel = rid[IDW];
    checkOutput("s0_rvalid", s0_r_rvalid, rv && !sel);
    checkOutput("s1_rvalid", s1_r_rvalid, rv && sel);
    checkOutput("m_rready", m_r_rready, sel ? rr1 : rr0);
    checkOutput("s0_rid", s0_r_rid, rid[IDW-1:0]);
    checkOutput("s1_rid", s1_r_rid, rid[IDW-1:0]);
    checkOutput("s1_rdata", s1_r_rdata, m_r_rdata);
    checkOutput("s0_rlast", s0_r_rlast, rl);
    checkOutput("busy", busy_o, m_vld || (cnt[0] != 0) || (cnt[1] != 0));
    checkOutput("err", err_o, err_m);
    if (m_ar_arvalid && m_ar_arready) dut_hs++;
    rhs = rv && (sel ? rr1 : rr0);
    @(posedge clk_i);
    if (rhs && cnt[sel] == 0) err_m = 1'b1;
    for (int n = 0; n < 2; n++) begin
      inc = (n == 0) ? g0 : g1;
      dec = rhs && rl && (int'(sel) == n);
      if (inc && !dec) cnt[n]++;
      else if (dec && !inc && cnt[n] > 0) cnt[n]--;
    end
    if (m_vld && mrdy) begin
      if (auto_resp) resp_q.push_back(exp_q[0].id);
      void'(exp_q.pop_front());
    end
    if (gp_valid) begin
      e.id   = {gp, (gp ? (seq[1][IDW-1:0] ^ 4'hA) : seq[0][IDW-1:0])};
      e.addr = (gp ? 64'hB000_0000_0000_0000 : 64'hA000_0000_0000_0000) | 64'(seq[gp]);
      e.len  = gp ? 8'(seq[1] + 128) : 8'(seq[0]);
      exp_q.push_back(e);
      m_vld = 1'b1;
      ptr   = !gp;
      seq[gp]++;
      grants_total++;
    end else if (m_vld && mrdy) begin
      m_vld = 1'b0;
    end
    #2;
  endtask

  // Return single-beat bursts until nothing is outstanding.
  task automatic drainAll();
    int  budget;
    bit  p;
    logic any;
    budget = 64;
    while (((cnt[0] != 0) || (cnt[1] != 0) || m_vld) && budget > 0) begin
      any = (cnt[0] != 0) || (cnt[1] != 0);
      p   = (cnt[0] != 0) ? 1'b0 : 1'b1;
      applyStimulus(0, 0, 1, any, {p, 4'h0}, 1, 1, 1);
      budget--;
    end
    checkOutput("drain_done", 64'(budget > 0), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    int budget;
    int beat;
    logic rr;
    logic rv;
    logic [IDW:0] rid;

    seq[0] = 0;
    seq[1] = 0;
    grants_total = 0;
    dut_hs = 0;
    auto_resp = 1'b0;
    resetModel();
    rst_i = 1'b1;
    drivePayload();
    s0_ar_arvalid = 1'b1;
    s1_ar_arvalid = 1'b1;
    m_ar_arready = 1'b1;
    m_r_rvalid = 1'b0;
    m_r_rid = '0;
    m_r_rlast = 1'b0;
    m_r_rresp = '0;
    m_r_rdata = '0;
    s0_r_rready = 1'b0;
    s1_r_rready = 1'b0;
    #12;
    $display("[TB] reset state");
    checkOutput("rst_m_arvalid", m_ar_arvalid, 0);
    checkOutput("rst_s0_arready", s0_ar_arready, 0);
    checkOutput("rst_s1_arready", s1_ar_arready, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_m_araddr", m_ar_araddr, 0);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;

    $display("[TB] round robin, 100 requests");
    auto_resp = 1'b1;
    start = grants_total;
    dut_hs = 0;
    budget = 400;
    while ((grants_total - start) < 100 && budget > 0) begin
      rv  = (resp_q.size() > 0);
      rid = rv ? resp_q[0] : '0;
      applyStimulus(1, 1, 1, rv, rid, 1, 1, 1);
      if (rv) void'(resp_q.pop_front());
      budget--;
    end
    budget = 20;
    while ((resp_q.size() > 0 || m_vld) && budget > 0) begin
      rv  = (resp_q.size() > 0);
      rid = rv ? resp_q[0] : '0;
      applyStimulus(0, 0, 1, rv, rid, 1, 1, 1);
      if (rv) void'(resp_q.pop_front());
      budget--;
    end
    auto_resp = 1'b0;
    checkOutput("rr_ar_handshakes", dut_hs, 100);
    drainAll();

    $display("[TB] throttle at MAX_TXNS");
    for (int i = 0; i < MAXT + 2; i++) applyStimulus(1, 0, 1, 0, '0, 0, 1, 1);
    checkOutput("thr_arready_low", s0_ar_arready, 0);
    checkOutput("thr_busy", busy_o, 1);
    applyStimulus(1, 0, 1, 1, 5'b0_0011, 1, 1, 1);
    applyStimulus(1, 0, 1, 0, '0, 0, 1, 1);
    drainAll();

    $display("[TB] master stall");
    applyStimulus(1, 1, 1, 0, '0, 0, 1, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, '0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0, '0, 0, 1, 1);
    drainAll();

    $display("[TB] four-beat burst to s1 with throttled rready");
    applyStimulus(0, 1, 1, 0, '0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0, '0, 0, 1, 1);
    beat = 0;
    rr = 1'b0;
    budget = 20;
    while (beat < 4 && budget > 0) begin
      applyStimulus(0, 0, 1, 1, 5'b1_0111, (beat == 3), 1, rr);
      if (rr) beat++;
      rr = !rr;
      budget--;
    end
    checkOutput("burst_done", beat, 4);
    checkOutput("burst_busy", busy_o, 0);

    $display("[TB] R beat with nothing outstanding");
    applyStimulus(0, 0, 1, 1, 5'b0_0101, 1, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, '0, 0, 1, 1);
    checkOutput("err_sticky", err_o, 1);
    checkOutput("err_busy", busy_o, 0);

    $display("[TB] asynchronous reset mid-operation");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, '0, 0, 1, 1);
    m_r_rvalid = 1'b1;
    m_r_rid    = 5'b0_0001;
    m_r_rlast  = 1'b0;
    rst_i = 1'b1;
    #1;
    checkOutput("arst_m_arvalid", m_ar_arvalid, 0);
    checkOutput("arst_busy", busy_o, 0);
    checkOutput("arst_err", err_o, 0);
    checkOutput("arst_s0_arready", s0_ar_arready, 0);
    checkOutput("arst_m_arid", m_ar_arid, 0);
    resetModel();
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    applyStimulus(1, 1, 1, 0, '0, 0, 1, 1);
    applyStimulus(1, 1, 1, 0, '0, 0, 1, 1);
    drainAll();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
